// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Message codes match the decoder stage's lookup table.
package display_pkg;

    localparam int CONT_W = 2;

    localparam logic [2:0] MSG_OFF  = 3'b000;
    localparam logic [2:0] MSG_PARE = 3'b001;
    localparam logic [2:0] MSG_OCUP = 3'b010;
    localparam logic [2:0] MSG_SIGA = 3'b011;
    localparam logic [2:0] MSG_ERRO = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHOW_ON  = 2'b01,
        SHOW_OFF = 2'b10
    } state_t;

    // Codes above erro are not defined by the decoder; show them as blank.
    function automatic logic [2:0] msg_sanitise(input logic [2:0] m);
        return (m > MSG_ERRO) ? MSG_OFF : m;
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Bundle between the message controller, the scan driver and the decoder.
// master = controller/decoder side, slave = display_scan.
interface display_scan_if;
    import display_pkg::*;

    logic [2:0]        msg_in;
    logic              msg_load;
    logic              blink_en;
    logic [CONT_W-1:0] cont;
    logic [2:0]        dis;
    logic              frame_tick;

    modport master (
        output msg_in, msg_load, blink_en,
        input  cont, dis, frame_tick
    );

    modport slave (
        input  msg_in, msg_load, blink_en,
        output cont, dis, frame_tick
    );

endinterface

// File: rtl/display_scan_tick_gen.sv
// Free-running prescaler: tick is high on the last count of each period.
// Counter width is at least one bit so DIV=1 still elaborates.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Digit scan and message state for the 4-digit seven-segment decoder.
// Holds a requested message, blinks it per frame and clears it on timeout.
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int HOLD_FRAMES  = 750
) (
    input  logic         clock,
    input  logic         reset,
    display_scan_if.slave bus
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST =
        BLINK_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam bit HOLD_ON = (HOLD_FRAMES != 0);

    logic              w_tick;
    logic              w_frame;
    logic [2:0]        w_msg_san;

    logic [CONT_W-1:0] r_cont;
    logic              r_frame_tick;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_msg;
    logic [2:0]        w_msg_nxt;
    logic              r_blink;
    logic              w_blink_nxt;
    logic [BLINK_W-1:0] r_bcnt;
    logic [BLINK_W-1:0] w_bcnt_nxt;
    logic [HOLD_W-1:0] r_hcnt;
    logic [HOLD_W-1:0] w_hcnt_nxt;
    logic [2:0]        r_dis;
    logic [2:0]        w_dis_nxt;

    tick_gen #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_frame   = w_tick && (r_cont == CONT_W'(3));
    assign w_msg_san = msg_sanitise(bus.msg_in);

    assign bus.cont       = r_cont;
    assign bus.dis        = r_dis;
    assign bus.frame_tick = r_frame_tick;

    // Digit select advances once per slot; frame pulse follows the 11->00 wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont       <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cont <= r_cont + 1'b1;
            end
            r_frame_tick <= w_frame;
        end
    end

    // Message state register, counters and registered display code.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_msg   <= MSG_OFF;
            r_blink <= 1'b0;
            r_bcnt  <= '0;
            r_hcnt  <= '0;
            r_dis   <= MSG_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_msg   <= w_msg_nxt;
            r_blink <= w_blink_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_dis   <= w_dis_nxt;
        end
    end

    // Next state: a load beats timeout and blink; timeout beats blink.
    always_comb begin
        w_state_nxt = r_state;
        w_msg_nxt   = r_msg;
        w_blink_nxt = r_blink;
        w_bcnt_nxt  = r_bcnt;
        w_hcnt_nxt  = r_hcnt;

        if (bus.msg_load) begin
            w_msg_nxt   = w_msg_san;
            w_blink_nxt = bus.blink_en;
            w_bcnt_nxt  = '0;
            w_hcnt_nxt  = '0;
            w_state_nxt = (w_msg_san == MSG_OFF) ? IDLE : SHOW_ON;
        end else if (w_frame && (r_state != IDLE)) begin
            if (HOLD_ON && (r_msg != MSG_ERRO) && (r_hcnt == HOLD_LAST)) begin
                w_msg_nxt   = MSG_OFF;
                w_state_nxt = IDLE;
                w_bcnt_nxt  = '0;
                w_hcnt_nxt  = '0;
            end else begin
                if (HOLD_ON && (r_hcnt != HOLD_LAST)) begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
                if (r_blink) begin
                    if (r_bcnt == BLINK_LAST) begin
                        w_bcnt_nxt = '0;
                        unique case (r_state)
                            SHOW_ON:  w_state_nxt = SHOW_OFF;
                            SHOW_OFF: w_state_nxt = SHOW_ON;
                            default:  w_state_nxt = r_state;
                        endcase
                    end else begin
                        w_bcnt_nxt = r_bcnt + 1'b1;
                    end
                end
            end
        end

        w_dis_nxt = (w_state_nxt == SHOW_ON) ? w_msg_nxt : MSG_OFF;
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a 16-cycle frame.
// Expected values are hand-derived from the edge count since reset release.
module tb_display_scan;

    logic clock = 1'b0;
    logic reset;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    display_scan_if bus ();

    display_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .HOLD_FRAMES  (3)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp_v);
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic go(input int target);
        while (cyc < target) adv(1);
    endtask

    task automatic load(input logic [2:0] m, input logic b);
        bus.msg_in   = m;
        bus.blink_en = b;
        bus.msg_load = 1'b1;
        adv(1);
        bus.msg_load = 1'b0;
    endtask

    function automatic logic [7:0] exp_cont();
        return 8'((cyc >> 2) & 3);
    endfunction

    function automatic logic [7:0] exp_ft();
        return (cyc > 0 && (cyc % 16) == 0) ? 8'd1 : 8'd0;
    endfunction

    initial begin
        reset        = 1'b1;
        bus.msg_in   = 3'b000;
        bus.msg_load = 1'b0;
        bus.blink_en = 1'b0;
        cyc          = 0;

        // reset state
        adv(2);
        chk("rst_cont", 8'(bus.cont), 8'd0);
        chk("rst_dis", 8'(bus.dis), 8'd0);
        chk("rst_ft", 8'(bus.frame_tick), 8'd0);

        // free-run scan
        reset = 1'b0;
        cyc   = 0;
        for (int n = 1; n <= 40; n++) begin
            adv(1);
            chk("scan_cont", 8'(bus.cont), exp_cont());
            chk("scan_ft", 8'(bus.frame_tick), exp_ft());
            chk("scan_dis", 8'(bus.dis), 8'd0);
        end

        // siga, no blink, times out on third frame edge
        load(3'b011, 1'b0);
        chk("siga_lat", 8'(bus.dis), 8'd3);
        chk("siga_cont", 8'(bus.cont), exp_cont());
        go(48);
        chk("siga_f1", 8'(bus.dis), 8'd3);
        chk("siga_f1_ft", 8'(bus.frame_tick), 8'd1);
        go(79);
        chk("siga_pre_to", 8'(bus.dis), 8'd3);
        go(80);
        chk("siga_to", 8'(bus.dis), 8'd0);
        chk("siga_to_ft", 8'(bus.frame_tick), 8'd1);

        // pare with blink, timeout overrides blink
        load(3'b001, 1'b1);
        chk("pare_lat", 8'(bus.dis), 8'd1);
        go(96);
        chk("pare_f1", 8'(bus.dis), 8'd1);
        go(111);
        chk("pare_pre_off", 8'(bus.dis), 8'd1);
        go(112);
        chk("pare_off", 8'(bus.dis), 8'd0);
        go(127);
        chk("pare_off2", 8'(bus.dis), 8'd0);
        go(128);
        chk("pare_to", 8'(bus.dis), 8'd0);
        go(144);
        chk("pare_no_reblink", 8'(bus.dis), 8'd0);
        chk("pare_ft", 8'(bus.frame_tick), 8'd1);
        go(145);

        // erro never times out
        load(3'b100, 1'b0);
        chk("erro_lat", 8'(bus.dis), 8'd4);
        for (int k = 0; k < 20; k++) begin
            go(160 + 16 * k);
            chk("erro_hold", 8'(bus.dis), 8'd4);
        end
        go(470);
        load(3'b000, 1'b0);
        chk("off_lat", 8'(bus.dis), 8'd0);
        go(480);
        chk("off_idle", 8'(bus.dis), 8'd0);

        // invalid code sanitised
        load(3'b111, 1'b0);
        chk("bad_code", 8'(bus.dis), 8'd0);

        // load on the exact timeout edge wins and restarts hold
        load(3'b011, 1'b0);
        chk("siga2_lat", 8'(bus.dis), 8'd3);
        go(527);
        chk("siga2_pre", 8'(bus.dis), 8'd3);
        load(3'b010, 1'b0);
        chk("ocup_on_to", 8'(bus.dis), 8'd2);
        chk("ocup_ft", 8'(bus.frame_tick), 8'd1);
        go(544);
        chk("ocup_f1", 8'(bus.dis), 8'd2);
        go(575);
        chk("ocup_pre_to", 8'(bus.dis), 8'd2);
        go(576);
        chk("ocup_to", 8'(bus.dis), 8'd0);

        // reset beats a simultaneous load
        load(3'b001, 1'b0);
        chk("pare2_lat", 8'(bus.dis), 8'd1);
        go(584);
        chk("pre_rst_cont", 8'(bus.cont), 8'd2);
        chk("pre_rst_dis", 8'(bus.dis), 8'd1);
        reset        = 1'b1;
        bus.msg_in   = 3'b010;
        bus.msg_load = 1'b1;
        adv(1);
        chk("mid_rst_cont", 8'(bus.cont), 8'd0);
        chk("mid_rst_dis", 8'(bus.dis), 8'd0);
        chk("mid_rst_ft", 8'(bus.frame_tick), 8'd0);
        reset        = 1'b0;
        bus.msg_load = 1'b0;
        cyc          = 0;
        adv(1);
        chk("post_rst_dis", 8'(bus.dis), 8'd0);
        chk("post_rst_cont", 8'(bus.cont), 8'd0);
        go(4);
        chk("post_rst_cont4", 8'(bus.cont), 8'd1);
        go(16);
        chk("post_rst_ft", 8'(bus.frame_tick), 8'd1);
        chk("post_rst_dis16", 8'(bus.dis), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
